// File: rtl/rx_deserializer.sv
// Oversampling UART-style receiver: synchronizes serial_in, detects the start bit,
// samples each data bit near mid-bit and checks the stop bit.
module rx_deserializer #(
    parameter int data_length  = 8,
    parameter int dummy_period = 5
) (
    input  logic                   clk,
    input  logic                   prst,
    input  logic                   serial_in,
    output logic [data_length-1:0] rx_data,
    output logic                   rx_valid,
    output logic                   frame_error,
    output logic                   busy
);

    localparam int CNT_W = $clog2(dummy_period);
    localparam int IDX_W = (data_length > 1) ? $clog2(data_length) : 1;
    localparam logic [CNT_W-1:0] HALF_C     = CNT_W'((dummy_period - 1) / 2);
    localparam logic [CNT_W-1:0] LAST_C     = CNT_W'(dummy_period - 1);
    localparam logic [IDX_W-1:0] LAST_IDX_C = IDX_W'(data_length - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    logic                   sync_meta_r;
    logic                   sync_in_r;
    logic                   sync_prev_r;
    state_t                 state_r;
    logic [CNT_W-1:0]       cnt_r;
    logic [IDX_W-1:0]       idx_r;
    logic [data_length-1:0] shift_r;
    logic [data_length-1:0] rx_data_r;
    logic                   rx_valid_r;
    logic                   frame_error_r;

    // Two-flop synchronizer plus delayed copy for falling-edge detection; resets to idle-high.
    always_ff @(posedge clk) begin
        if (!prst) begin
            sync_meta_r <= 1'b1;
            sync_in_r   <= 1'b1;
            sync_prev_r <= 1'b1;
        end else begin
            sync_meta_r <= serial_in;
            sync_in_r   <= sync_meta_r;
            sync_prev_r <= sync_in_r;
        end
    end

    // Frame FSM with bit-period counter, bit index, shift register and registered pulses.
    always_ff @(posedge clk) begin
        if (!prst) begin
            state_r       <= IDLE;
            cnt_r         <= {CNT_W{1'b0}};
            idx_r         <= {IDX_W{1'b0}};
            shift_r       <= {data_length{1'b0}};
            rx_data_r     <= {data_length{1'b0}};
            rx_valid_r    <= 1'b0;
            frame_error_r <= 1'b0;
        end else begin
            rx_valid_r    <= 1'b0;
            frame_error_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (sync_prev_r && !sync_in_r) begin
                        state_r <= START;
                        cnt_r   <= {CNT_W{1'b0}};
                    end else begin
                        state_r <= IDLE;
                    end
                end
                START: begin
                    if (cnt_r == HALF_C) begin
                        cnt_r <= {CNT_W{1'b0}};
                        idx_r <= {IDX_W{1'b0}};
                        // A start bit that is already high again at half-bit was a glitch.
                        if (!sync_in_r) begin
                            state_r <= DATA;
                        end else begin
                            state_r <= IDLE;
                        end
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end
                DATA: begin
                    if (cnt_r == LAST_C) begin
                        shift_r[idx_r] <= sync_in_r;
                        cnt_r          <= {CNT_W{1'b0}};
                        if (idx_r == LAST_IDX_C) begin
                            state_r <= STOP;
                            idx_r   <= {IDX_W{1'b0}};
                        end else begin
                            idx_r <= idx_r + IDX_W'(1);
                        end
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end
                STOP: begin
                    if (cnt_r == LAST_C) begin
                        cnt_r   <= {CNT_W{1'b0}};
                        state_r <= IDLE;
                        if (sync_in_r) begin
                            rx_data_r  <= shift_r;
                            rx_valid_r <= 1'b1;
                        end else begin
                            frame_error_r <= 1'b1;
                        end
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end
                default: begin
                    state_r <= IDLE;
                    cnt_r   <= {CNT_W{1'b0}};
                    idx_r   <= {IDX_W{1'b0}};
                end
            endcase
        end
    end

    assign rx_data     = rx_data_r;
    assign rx_valid    = rx_valid_r;
    assign frame_error = frame_error_r;
    assign busy        = (state_r != IDLE);

endmodule

// File: tb/tb_rx_deserializer.sv
// Directed bench for rx_deserializer: frames are queued as expectations when sent
// and matched against rx_valid / frame_error pulses by a negedge monitor.
module tb_rx_deserializer;

    localparam int N = 8;
    localparam int P = 5;
    localparam int H = (P - 1) / 2;
    localparam int FRAME = (N + 2) * P;

    typedef struct {
        logic         is_err;
        logic [N-1:0] data;
    } exp_t;

    logic         clk;
    logic         prst;
    logic         serial_in;
    logic [N-1:0] rx_data;
    logic         rx_valid;
    logic         frame_error;
    logic         busy;

    exp_t         exp_q[$];
    int           tests_run;
    int           tests_failed;
    int           valid_cnt;
    int           err_cnt;
    int           cyc;
    int           start_cyc;
    int           valid_cyc;
    logic [N-1:0] last_good;

    rx_deserializer #(.data_length(N), .dummy_period(P)) dut (
        .clk         (clk),
        .prst        (prst),
        .serial_in   (serial_in),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .frame_error (frame_error),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests_run++;
        assert (obs === expv) else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Scoreboard monitor: every output pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        exp_t e;
        if (rx_valid === 1'b1 || frame_error === 1'b1) begin
            chk("exclusive_pulse", {31'd0, rx_valid & frame_error}, 32'd0);
            chk("pulse_expected", {31'd0, exp_q.size() != 0}, 32'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                if (rx_valid === 1'b1) begin
                    valid_cnt++;
                    valid_cyc = cyc;
                    chk("valid_kind", {31'd0, e.is_err}, 32'd0);
                    chk("rx_data", {24'd0, rx_data}, {24'd0, e.data});
                    last_good = e.data;
                end else begin
                    err_cnt++;
                    chk("error_kind", {31'd0, e.is_err}, 32'd1);
                    chk("rx_data_hold", {24'd0, rx_data}, {24'd0, last_good});
                end
            end
        end
    end

    task automatic send_bit(input logic b);
        serial_in = b;
        repeat (P) @(negedge clk);
    endtask

    task automatic send_frame(input logic push, input logic [N-1:0] d, input logic stop_b);
        exp_t e;
        if (push) begin
            e.is_err = ~stop_b;
            e.data   = d;
            exp_q.push_back(e);
        end
        start_cyc = cyc;
        send_bit(1'b0);
        for (int i = 0; i < N; i++) send_bit(d[i]);
        send_bit(stop_b);
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 4 * FRAME && exp_q.size() != 0; i++) @(negedge clk);
        chk(tag, exp_q.size(), 32'd0);
        repeat (P) @(negedge clk);
    endtask

    initial begin
        int v0;
        int e0;
        int busy_cycles;
        int lat;
        tests_run    = 0;
        tests_failed = 0;
        valid_cnt    = 0;
        err_cnt      = 0;
        cyc          = 0;
        start_cyc    = 0;
        valid_cyc    = 0;
        last_good    = '0;
        serial_in    = 1'b1;
        prst         = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("reset_rx_data", {24'd0, rx_data}, 32'd0);
        chk("reset_rx_valid", {31'd0, rx_valid}, 32'd0);
        chk("reset_frame_error", {31'd0, frame_error}, 32'd0);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        prst = 1'b1;
        repeat (4) @(negedge clk);

        // Single good frame with latency check
        v0 = valid_cnt; e0 = err_cnt;
        send_frame(1'b1, 8'hA5, 1'b1);
        drain("a5_drain");
        chk("a5_valid_count", valid_cnt - v0, 32'd1);
        chk("a5_err_count", err_cnt - e0, 32'd0);
        chk("a5_busy_after", {31'd0, busy}, 32'd0);
        chk("a5_rx_data", {24'd0, rx_data}, 32'hA5);
        lat = valid_cyc - start_cyc;
        chk("a5_latency", {31'd0, (lat >= FRAME + 1) && (lat <= FRAME + 3)}, 32'd1);

        // Back-to-back frames, no idle gap
        v0 = valid_cnt; e0 = err_cnt;
        send_frame(1'b1, 8'h00, 1'b1);
        send_frame(1'b1, 8'hFF, 1'b1);
        drain("b2b_drain");
        chk("b2b_valid_count", valid_cnt - v0, 32'd2);
        chk("b2b_err_count", err_cnt - e0, 32'd0);
        chk("b2b_rx_data", {24'd0, rx_data}, 32'hFF);

        // Stop bit low
        v0 = valid_cnt; e0 = err_cnt;
        send_frame(1'b1, 8'h3C, 1'b0);
        serial_in = 1'b1;
        drain("ferr_drain");
        chk("ferr_err_count", err_cnt - e0, 32'd1);
        chk("ferr_valid_count", valid_cnt - v0, 32'd0);
        chk("ferr_rx_data", {24'd0, rx_data}, 32'hFF);

        // One-cycle low glitch on idle line
        v0 = valid_cnt; e0 = err_cnt;
        busy_cycles = 0;
        serial_in = 1'b0;
        @(negedge clk);
        serial_in = 1'b1;
        for (int i = 0; i < 2 * FRAME; i++) begin
            @(negedge clk);
            if (busy === 1'b1) busy_cycles++;
        end
        chk("glitch_entered_start", {31'd0, busy_cycles > 0}, 32'd1);
        chk("glitch_busy_bound", {31'd0, busy_cycles <= H + 1}, 32'd1);
        chk("glitch_no_pulse", (valid_cnt - v0) + (err_cnt - e0), 32'd0);

        // Reset during bit 4 of 0x5A, then a normal frame
        v0 = valid_cnt; e0 = err_cnt;
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'(8'h5A >> i));
        serial_in = 1'b1;
        repeat (2) @(negedge clk);
        prst = 1'b0;
        @(negedge clk);
        prst = 1'b1;
        last_good = '0;
        repeat (2 * FRAME) @(negedge clk);
        chk("abort_no_pulse", (valid_cnt - v0) + (err_cnt - e0), 32'd0);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        send_frame(1'b1, 8'h81, 1'b1);
        drain("after_abort_drain");
        chk("after_abort_valid_count", valid_cnt - v0, 32'd1);
        chk("after_abort_rx_data", {24'd0, rx_data}, 32'h81);

        // Line held low (break) for three frame lengths
        v0 = valid_cnt; e0 = err_cnt;
        send_frame(1'b1, 8'h55, 1'b0);
        serial_in = 1'b0;
        repeat (3 * FRAME) @(negedge clk);
        chk("break_err_count", err_cnt - e0, 32'd1);
        chk("break_valid_count", valid_cnt - v0, 32'd0);
        chk("break_busy", {31'd0, busy}, 32'd0);
        serial_in = 1'b1;
        repeat (2 * P) @(negedge clk);
        chk("break_release_quiet", (valid_cnt - v0) + (err_cnt - e0), 32'd1);
        send_frame(1'b1, 8'h42, 1'b1);
        drain("after_break_drain");
        chk("after_break_valid_count", valid_cnt - v0, 32'd1);
        chk("after_break_rx_data", {24'd0, rx_data}, 32'h42);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/rx_deserializer.md
RX_DESERIALIZER -- requirements
Module: rx_deserializer

Interface
REQ-001 Parameter data_length, default 8: data bits per frame, sent LSB first; SHALL be within 1..16.
REQ-002 Parameter dummy_period, default 5: clock cycles per bit period; SHALL be at least 3.
REQ-003 Port clk, input, 1: sole clock; all state updates on its rising edge.
REQ-004 Port prst, input, 1: reset, synchronous and active-low.
REQ-005 Port serial_in, input, 1: asynchronous serial line; idles high.
REQ-006 Port rx_data, output, data_length: last correctly framed word.
REQ-007 Port rx_valid, output, 1: one-cycle pulse when rx_data is updated.
REQ-008 Port frame_error, output, 1: one-cycle pulse when the stop bit is sampled low.
REQ-009 Port busy, output, 1: high in every state except IDLE.

Function
REQ-010 serial_in SHALL pass through a 2-flop synchronizer; all logic below SHALL use only the synchronized value (sync_in) and its one-cycle-delayed copy (sync_prev).
REQ-011 The FSM SHALL have exactly four states: IDLE, START, DATA, STOP.
REQ-012 A frame is: start bit low, data_length data bits LSB first, stop bit high; each bit lasts dummy_period cycles.
REQ-013 Half-bit point H = (dummy_period-1)/2, integer division.
REQ-014 IDLE: on sync_prev=1 and sync_in=0 (falling edge) -> START with counter=0; otherwise remain in IDLE.
REQ-015 START: increment counter each cycle; at counter=H sample sync_in: if 0 -> DATA with counter=0 and bit index=0; if 1 (glitch) -> IDLE with no output pulse.
REQ-016 DATA: increment counter each cycle; at counter=dummy_period-1, store sync_in in shift bit [bit index], reset counter to 0, increment bit index; this makes each sample fall at mid-bit.
REQ-017 DATA -> STOP on the cycle the bit at index data_length-1 is stored.
REQ-018 STOP: at counter=dummy_period-1 sample sync_in: if 1, load rx_data from shift register and pulse rx_valid on the next cycle; if 0, pulse frame_error on the next cycle and leave rx_data unchanged; return to IDLE in either case.
REQ-019 After STOP, a new frame SHALL be accepted only after a fresh falling edge; a line held low (break) SHALL NOT generate further frames or errors.
REQ-020 rx_valid and frame_error SHALL never be high in the same cycle; each is high for exactly one cycle per frame.
REQ-021 Counter and bit index SHALL be sized from the parameters and SHALL NOT wrap within a frame.
REQ-022 serial_in activity during START, DATA or STOP other than at the sample points SHALL have no effect.
REQ-023 Latency: the rx_valid pulse appears 2 cycles (synchronizer) plus one frame length after the start-bit falling edge on serial_in, within ±1 cycle.

Reset
REQ-024 With prst=0 at a clock edge: state=IDLE, counter=0, bit index=0, shift register=0, rx_data=0, rx_valid=0, frame_error=0, and both synchronizer flops plus sync_prev=1.
REQ-025 Reset asserted mid-frame SHALL abandon the frame with no rx_valid or frame_error pulse; the next frame after release SHALL be received normally.

Verification
REQ-026 Defaults, frame 0xA5 with correct stop bit -> exactly one rx_valid pulse, rx_data=0xA5, frame_error stays 0, busy low afterwards.
REQ-027 Back-to-back frames 0x00 then 0xFF with no idle gap -> two rx_valid pulses, with rx_data=0x00 and then 0xFF.
REQ-028 Frame 0x3C with stop bit driven low -> one frame_error pulse, no rx_valid, rx_data retains the previous value.
REQ-029 Low glitch of 1 cycle on an idle line -> START then IDLE, no rx_valid or frame_error pulse, busy high for at most H+1 cycles.
REQ-030 prst=0 pulsed during bit 4 of frame 0x5A, then frame 0x81 -> no pulse for the aborted frame; one rx_valid pulse with rx_data=0x81.
REQ-031 Line held low for 3 frame lengths after a frame -> exactly one frame_error pulse and no further output until the line returns high and a new frame is sent.
